// File: rtl/synthesizer_channel_scheduler_pkg.sv
// Shared DSP types for the channelizer -> synthesizer path: control structs,
// scheduler state encoding and a mask popcount helper.
package dsp_pkg;

  localparam int unsigned DSP_NUM_CHANNELS        = 16;
  localparam int unsigned DSP_CHANNEL_INDEX_WIDTH = $clog2(DSP_NUM_CHANNELS);
  localparam int unsigned DSP_DATA_WIDTH          = 19;

  typedef struct packed {
    logic                               valid;
    logic                               last;
    logic [DSP_CHANNEL_INDEX_WIDTH-1:0] data_index;
  } channelizer_control_t;

  typedef struct packed {
    logic                               valid;
    logic                               last;
    logic [DSP_CHANNEL_INDEX_WIDTH-1:0] data_index;
    logic [DSP_CHANNEL_INDEX_WIDTH:0]   active_channel_count;
  } synthesizer_control_t;

  typedef enum logic {
    S_SYNC = 1'b0,
    S_RUN  = 1'b1
  } scheduler_state_t;

  function automatic logic [DSP_CHANNEL_INDEX_WIDTH:0] popcount(
    input logic [DSP_NUM_CHANNELS-1:0] mask
  );
    logic [DSP_CHANNEL_INDEX_WIDTH:0] count;
    count = '0;
    for (int unsigned i = 0; i < DSP_NUM_CHANNELS; i++) begin
      count += {{DSP_CHANNEL_INDEX_WIDTH{1'b0}}, mask[i]};
    end
    return count;
  endfunction

endpackage

// File: rtl/synthesizer_channel_scheduler.sv
// Gates channelizer channels into the synthesizer with a frame-atomic enable
// mask, and holds output off until the input stream is frame-aligned.
module synthesizer_channel_scheduler
  import dsp_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS        = DSP_NUM_CHANNELS,
  parameter int unsigned CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
  parameter int unsigned DATA_WIDTH          = DSP_DATA_WIDTH
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         Config_valid,
  input  logic [NUM_CHANNELS-1:0]      Config_mask,
  output logic                         Config_ack,
  input  channelizer_control_t         Input_ctrl,
  input  logic signed [DATA_WIDTH-1:0] Input_data [2],
  output synthesizer_control_t         Output_ctrl,
  output logic signed [DATA_WIDTH-1:0] Output_data [2],
  output logic [NUM_CHANNELS-1:0]      Active_mask,
  output logic                         Error_frame_sequence,
  output logic                         Error_config_overflow
);

  localparam logic [CHANNEL_INDEX_WIDTH-1:0] LAST_INDEX = CHANNEL_INDEX_WIDTH'(NUM_CHANNELS - 1);

  scheduler_state_t                 state_q, state_d;
  logic [CHANNEL_INDEX_WIDTH-1:0]   expected_q, expected_d;
  logic [NUM_CHANNELS-1:0]          active_mask_q, active_mask_d;
  logic [NUM_CHANNELS-1:0]          pending_mask_q, pending_mask_d;
  logic                             pending_q, pending_d;
  synthesizer_control_t             out_ctrl_q, out_ctrl_d;
  logic signed [DATA_WIDTH-1:0]     out_data_q [2];
  logic signed [DATA_WIDTH-1:0]     out_data_d [2];
  logic                             ack_q, ack_d;
  logic                             err_seq_q, err_seq_d;
  logic                             err_ovf_q, err_ovf_d;
  logic                             beat_ok;
  logic                             beat_err;
  logic                             apply;

  always_comb begin
    state_d        = state_q;
    expected_d     = expected_q;
    active_mask_d  = active_mask_q;
    pending_mask_d = pending_mask_q;
    pending_d      = pending_q;
    out_ctrl_d     = '0;
    out_data_d[0]  = '0;
    out_data_d[1]  = '0;
    beat_ok        = 1'b0;
    beat_err       = 1'b0;
    apply          = 1'b0;

    case (state_q)
      S_SYNC: begin
        if (Input_ctrl.valid && Input_ctrl.last) begin
          state_d    = S_RUN;
          expected_d = '0;
        end
      end
      S_RUN: begin
        if (Input_ctrl.valid) begin
          // last must coincide exactly with the final channel index
          if ((Input_ctrl.data_index != expected_q) ||
              (Input_ctrl.last != (Input_ctrl.data_index == LAST_INDEX))) begin
            beat_err = 1'b1;
            state_d  = S_SYNC;
          end else begin
            beat_ok    = 1'b1;
            expected_d = Input_ctrl.last ? '0 : expected_q + CHANNEL_INDEX_WIDTH'(1);
          end
        end
      end
      default: state_d = S_SYNC;
    endcase

    if (beat_ok) begin
      out_ctrl_d.valid                = 1'b1;
      out_ctrl_d.last                 = Input_ctrl.last;
      out_ctrl_d.data_index           = Input_ctrl.data_index;
      out_ctrl_d.active_channel_count = popcount(active_mask_q);
      if (active_mask_q[Input_ctrl.data_index]) begin
        out_data_d[0] = Input_data[0];
        out_data_d[1] = Input_data[1];
      end
    end

    apply = beat_ok && Input_ctrl.last && pending_q;
    if (apply) begin
      active_mask_d = pending_mask_q;
      pending_d     = 1'b0;
    end
    // A request on the apply edge replaces the slot just emptied, so it is not an overflow
    if (Config_valid) begin
      pending_mask_d = Config_mask;
      pending_d      = 1'b1;
    end

    ack_d     = apply;
    err_seq_d = beat_err;
    err_ovf_d = Config_valid && pending_q && !apply;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q        <= S_SYNC;
      expected_q     <= '0;
      active_mask_q  <= '0;
      pending_mask_q <= '0;
      pending_q      <= 1'b0;
      out_ctrl_q     <= '0;
      out_data_q[0]  <= '0;
      out_data_q[1]  <= '0;
      ack_q          <= 1'b0;
      err_seq_q      <= 1'b0;
      err_ovf_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      active_mask_q  <= active_mask_d;
      pending_mask_q <= pending_mask_d;
      pending_q      <= pending_d;
      out_ctrl_q     <= out_ctrl_d;
      out_data_q[0]  <= out_data_d[0];
      out_data_q[1]  <= out_data_d[1];
      ack_q          <= ack_d;
      err_seq_q      <= err_seq_d;
      err_ovf_q      <= err_ovf_d;
    end
  end

  assign Output_ctrl           = out_ctrl_q;
  assign Output_data[0]        = out_data_q[0];
  assign Output_data[1]        = out_data_q[1];
  assign Active_mask           = active_mask_q;
  assign Config_ack            = ack_q;
  assign Error_frame_sequence  = err_seq_q;
  assign Error_config_overflow = err_ovf_q;

endmodule

// File: tb/tb_synthesizer_channel_scheduler.sv
// Directed bench for synthesizer_channel_scheduler: alignment, mask apply
// timing, config overflow, sequencing errors and mid-frame reset.
module tb_synthesizer_channel_scheduler;
  import dsp_pkg::*;

  logic                 Clk;
  logic                 Rst_n;
  logic                 Config_valid;
  logic [15:0]          Config_mask;
  logic                 Config_ack;
  channelizer_control_t Input_ctrl;
  logic signed [18:0]   Input_data [2];
  synthesizer_control_t Output_ctrl;
  logic signed [18:0]   Output_data [2];
  logic [15:0]          Active_mask;
  logic                 Error_frame_sequence;
  logic                 Error_config_overflow;

  int n_assert = 0;
  int n_fail   = 0;

  synthesizer_channel_scheduler #(
    .NUM_CHANNELS        (16),
    .CHANNEL_INDEX_WIDTH (4),
    .DATA_WIDTH          (19)
  ) dut (
    .Clk                   (Clk),
    .Rst_n                 (Rst_n),
    .Config_valid          (Config_valid),
    .Config_mask           (Config_mask),
    .Config_ack            (Config_ack),
    .Input_ctrl            (Input_ctrl),
    .Input_data            (Input_data),
    .Output_ctrl           (Output_ctrl),
    .Output_data           (Output_data),
    .Active_mask           (Active_mask),
    .Error_frame_sequence  (Error_frame_sequence),
    .Error_config_overflow (Error_config_overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [18:0] sample(input int f, input int idx);
    return 19'(100 * f + idx + 1);
  endfunction

  // Drive one input beat and check the registered response one edge later
  task automatic beat(input int idx, input bit last, input bit cfgv, input logic [15:0] cfgm,
                      input int f, input bit exp_v, input logic [15:0] mask, input int cnt,
                      input bit exp_ack, input bit exp_err, input bit exp_ovf);
    logic signed [18:0] di, ei, eq;
    di = sample(f, idx);
    @(negedge Clk);
    Input_ctrl.valid      = 1'b1;
    Input_ctrl.last       = last;
    Input_ctrl.data_index = 4'(idx);
    Input_data[0]         = di;
    Input_data[1]         = -di;
    Config_valid          = cfgv;
    Config_mask           = cfgm;
    @(posedge Clk);
    #1;
    if (exp_v) begin
      ei = mask[idx] ? di : 19'sd0;
      eq = mask[idx] ? -di : 19'sd0;
      chk("out_valid", 64'(Output_ctrl.valid), 64'(1'b1));
      chk("out_last", 64'(Output_ctrl.last), 64'(last));
      chk("out_index", 64'(Output_ctrl.data_index), 64'(idx));
      chk("out_count", 64'(Output_ctrl.active_channel_count), 64'(cnt));
      chk("out_i", {45'd0, Output_data[0]}, {45'd0, ei});
      chk("out_q", {45'd0, Output_data[1]}, {45'd0, eq});
    end else begin
      chk("ctrl_idle", 64'(Output_ctrl), 64'd0);
      chk("data_i_idle", {45'd0, Output_data[0]}, 64'd0);
      chk("data_q_idle", {45'd0, Output_data[1]}, 64'd0);
    end
    chk("config_ack", 64'(Config_ack), 64'(exp_ack));
    chk("err_seq", 64'(Error_frame_sequence), 64'(exp_err));
    chk("err_ovf", 64'(Error_config_overflow), 64'(exp_ovf));
  endtask

  task automatic frame(input int f, input logic [15:0] mask, input int cnt, input bit ack_last,
                       input int cfg1_at, input logic [15:0] cfg1_m,
                       input int cfg2_at, input logic [15:0] cfg2_m, input int ovf_at);
    for (int k = 0; k < 16; k++) begin
      beat(k, k == 15, (k == cfg1_at) || (k == cfg2_at), (k == cfg2_at) ? cfg2_m : cfg1_m,
           f, 1'b1, mask, cnt, ack_last && (k == 15), 1'b0, k == ovf_at);
      if (k == 0) chk("active_mask", 64'(Active_mask), 64'(mask));
    end
  endtask

  task automatic idle_beats(input int f, input int from, input int to);
    for (int k = from; k <= to; k++)
      beat(k, k == 15, 1'b0, 16'h0000, f, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    Rst_n        = 1'b0;
    Config_valid = 1'b1;
    Config_mask  = 16'hFFFF;
    Input_ctrl   = '{valid: 1'b1, last: 1'b1, data_index: 4'hF};
    Input_data[0] = 19'sd5;
    Input_data[1] = 19'sd7;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_ctrl", 64'(Output_ctrl), 64'd0);
    chk("rst_data_i", {45'd0, Output_data[0]}, 64'd0);
    chk("rst_mask", 64'(Active_mask), 64'd0);
    chk("rst_ack", 64'(Config_ack), 64'd0);
    chk("rst_errs", 64'({Error_frame_sequence, Error_config_overflow}), 64'd0);
    @(negedge Clk);
    Rst_n        = 1'b1;
    Config_valid = 1'b0;
    Input_ctrl   = '0;

    // Unaligned: nothing leaves until the first last has been seen
    idle_beats(0, 0, 15);
    frame(1, 16'h0000, 0, 1'b0, -1, 16'h0, -1, 16'h0, -1);
    frame(2, 16'h0000, 0, 1'b1,  3, 16'h0005, -1, 16'h0, -1);
    frame(3, 16'h0005, 2, 1'b0, -1, 16'h0, -1, 16'h0, -1);
    // Second request in one frame overwrites the first and flags overflow
    frame(4, 16'h0005, 2, 1'b1,  2, 16'h00FF, 5, 16'h8001, 5);
    // Request on the last beat with nothing pending lands one frame later
    frame(5, 16'h8001, 2, 1'b0, 15, 16'h0F0F, -1, 16'h0, -1);
    frame(6, 16'h8001, 2, 1'b1, -1, 16'h0, -1, 16'h0, -1);
    frame(7, 16'h0F0F, 8, 1'b0, -1, 16'h0, -1, 16'h0, -1);

    // Index 7 skipped: error, then silent until the next last
    for (int k = 0; k < 7; k++)
      beat(k, 1'b0, 1'b0, 16'h0, 8, 1'b1, 16'h0F0F, 8, 1'b0, 1'b0, 1'b0);
    beat(8, 1'b0, 1'b0, 16'h0, 8, 1'b0, 16'h0, 0, 1'b0, 1'b1, 1'b0);
    idle_beats(8, 9, 15);
    frame(9, 16'h0F0F, 8, 1'b1, 0, 16'hFFFF, -1, 16'h0, -1);

    // Mid-frame reset with all channels enabled
    for (int k = 0; k < 8; k++)
      beat(k, 1'b0, 1'b0, 16'h0, 10, 1'b1, 16'hFFFF, 16, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Rst_n                 = 1'b0;
    Input_ctrl.valid      = 1'b1;
    Input_ctrl.last       = 1'b0;
    Input_ctrl.data_index = 4'd8;
    @(posedge Clk);
    #1;
    chk("midrst_ctrl", 64'(Output_ctrl), 64'd0);
    chk("midrst_data_i", {45'd0, Output_data[0]}, 64'd0);
    chk("midrst_data_q", {45'd0, Output_data[1]}, 64'd0);
    chk("midrst_mask", 64'(Active_mask), 64'd0);
    chk("midrst_pulses", 64'({Config_ack, Error_frame_sequence, Error_config_overflow}), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    idle_beats(10, 9, 15);
    frame(11, 16'h0000, 0, 1'b0, -1, 16'h0, -1, 16'h0, -1);

    @(negedge Clk);
    Input_ctrl = '0;
    @(posedge Clk);
    #1;
    chk("tail_idle", 64'(Output_ctrl), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
